// File: rtl/pattern_generator_if.sv
// pattern_generator_if: request/serial-output bundle; PATGEN_ABORT_EN adds the abort request
interface pattern_generator_if #(parameter int CNT_W = 4);
  logic start;
  logic [1:0] sel;
  logic [CNT_W-1:0] count;
  logic w;
  logic x;
  logic y;
  logic last_bit;
  logic busy;
  logic done;
`ifdef PATGEN_ABORT_EN
  logic abort;
  modport master(output start, sel, count, abort, input w, x, y, last_bit, busy, done);
  modport slave(input start, sel, count, abort, output w, x, y, last_bit, busy, done);
`else
  modport master(output start, sel, count, input w, x, y, last_bit, busy, done);
  modport slave(input start, sel, count, output w, x, y, last_bit, busy, done);
`endif
endinterface

// File: rtl/pattern_generator.sv
// pattern_generator: serial W/X/Y pattern transmitter with repeats and gaps; PATGEN_ABORT_EN adds abort
module pattern_generator #(
  parameter int CNT_W = 4,
  parameter int GAP_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  pattern_generator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;
  state_t st, st_n;
  logic [1:0] pat, pat_n, idx, idx_n;
  logic [3:0] gcnt, gcnt_n;
  logic [CNT_W-1:0] rep, rep_n;
  logic all_mode, all_n;
  logic bit_n;
  function automatic logic [1:0] last_idx(input logic [1:0] p);
    return p == 2'd0 ? 2'd3 : p == 2'd1 ? 2'd2 : 2'd1;
  endfunction
  function automatic logic rom(input logic [1:0] p, input logic [1:0] i);
    return p == 2'd0 ? ~i[0] : p == 2'd1 ? 1'b1 : (i == 2'd0);
  endfunction
  // next state; outputs are decoded from the next state so they leave registered
  always_comb begin
    st_n = st;
    pat_n = pat;
    idx_n = idx;
    gcnt_n = gcnt;
    rep_n = rep;
    all_n = all_mode;
    if (st == IDLE) begin
      if (bus.start) begin
        st_n = SEND;
        all_n = bus.sel == 2'd3;
        pat_n = bus.sel == 2'd3 ? 2'd0 : bus.sel;
        rep_n = bus.count == '0 ? CNT_W'(1) : bus.count;
        idx_n = 2'd0;
      end
    end else if (st == SEND) begin
      if (idx == last_idx(pat)) begin
        st_n = GAP;
        gcnt_n = 4'd0;
      end else idx_n = idx + 2'd1;
    end else if (st == GAP) begin
      if (gcnt == 4'(GAP_CYCLES - 1)) begin
        idx_n = 2'd0;
        if (all_mode && pat != 2'd2) begin
          st_n = SEND;
          pat_n = pat + 2'd1;
        end else if (rep > CNT_W'(1)) begin
          st_n = SEND;
          rep_n = rep - CNT_W'(1);
          pat_n = all_mode ? 2'd0 : pat;
        end else st_n = FIN;
      end else gcnt_n = gcnt + 4'd1;
    end else st_n = IDLE;
`ifdef PATGEN_ABORT_EN
    if (bus.abort && (st == SEND || st == GAP)) st_n = IDLE;
`endif
    bit_n = st_n == SEND && rom(pat_n, idx_n);
  end
  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      pat <= 2'd0;
      idx <= 2'd0;
      gcnt <= 4'd0;
      rep <= '0;
      all_mode <= 1'b0;
      bus.w <= 1'b0;
      bus.x <= 1'b0;
      bus.y <= 1'b0;
      bus.last_bit <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      st <= st_n;
      pat <= pat_n;
      idx <= idx_n;
      gcnt <= gcnt_n;
      rep <= rep_n;
      all_mode <= all_n;
      bus.w <= bit_n && pat_n == 2'd0;
      bus.x <= bit_n && pat_n == 2'd1;
      bus.y <= bit_n && pat_n == 2'd2;
      bus.last_bit <= st_n == SEND && idx_n == last_idx(pat_n);
      bus.busy <= st_n == SEND || st_n == GAP;
      bus.done <= st_n == FIN;
    end
  end
endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator: directed checks of pattern_generator outputs, packed as {w,x,y,last_bit,busy,done}
module tb_pattern_generator;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int order[$];
  int m_busy, m_last, m_done;
  always #5 clk = ~clk;
  pattern_generator_if #(.CNT_W(4)) bus();
  pattern_generator #(.CNT_W(4), .GAP_CYCLES(2)) dut(.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [5:0] obs();
    return {bus.w, bus.x, bus.y, bus.last_bit, bus.busy, bus.done};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start(input logic [1:0] s, input logic [3:0] c);
    bus.sel = s;
    bus.count = c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic measure(input int budget);
    int ch = -1;
    logic [5:0] o;
    m_busy = 0;
    m_last = 0;
    m_done = 0;
    order.delete();
    for (int c = 0; c < budget && m_done == 0; c++) begin
      o = obs();
      if (o[5]) ch = 0;
      if (o[4]) ch = 1;
      if (o[3]) ch = 2;
      if (o[2]) begin
        order.push_back(ch);
        m_last++;
      end
      if (o[1]) m_busy++;
      if (o[0]) m_done++;
      step();
    end
    repeat (5) begin
      if (bus.done) m_done++;
      step();
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.sel = 2'd0;
    bus.count = 4'd0;
`ifdef PATGEN_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) step();
    total++;
    if (obs() !== 6'b0) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs(), 6'b0); end
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs() !== 6'b0) begin bad++; $display("FAIL reset_idle%0d got=%b want=%b", i, obs(), 6'b0); end
    end
  endtask
  task automatic test_single_w();
    logic [5:0] e [0:7];
    e = '{6'b100010, 6'b000010, 6'b100010, 6'b000110, 6'b000010, 6'b000010, 6'b000001, 6'b000000};
    pulse_start(2'd0, 4'd1);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs() !== e[i]) begin bad++; $display("FAIL single_w cyc%0d got=%b want=%b", i + 1, obs(), e[i]); end
      step();
    end
  endtask
  task automatic test_x_count0();
    logic [5:0] e [0:6];
    e = '{6'b010010, 6'b010010, 6'b010110, 6'b000010, 6'b000010, 6'b000001, 6'b000000};
    pulse_start(2'd1, 4'd0);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (obs() !== e[i]) begin bad++; $display("FAIL x_count0 cyc%0d got=%b want=%b", i + 1, obs(), e[i]); end
      step();
    end
  endtask
  task automatic test_all_mode();
    pulse_start(2'd3, 4'd3);
    measure(200);
    total++;
    if (m_done !== 1) begin bad++; $display("FAIL all_done got=%0d want=1", m_done); end
    total++;
    if (m_busy !== 45) begin bad++; $display("FAIL all_busy got=%0d want=45", m_busy); end
    total++;
    if (m_last !== 9) begin bad++; $display("FAIL all_lasts got=%0d want=9", m_last); end
    for (int i = 0; i < order.size(); i++) begin
      total++;
      if (order[i] !== i % 3) begin bad++; $display("FAIL all_order%0d got=%0d want=%0d", i, order[i], i % 3); end
    end
  endtask
  task automatic test_max_count();
    pulse_start(2'd2, 4'd15);
    measure(300);
    total++;
    if (m_done !== 1) begin bad++; $display("FAIL max_done got=%0d want=1", m_done); end
    total++;
    if (m_busy !== 60) begin bad++; $display("FAIL max_busy got=%0d want=60", m_busy); end
    total++;
    if (m_last !== 15) begin bad++; $display("FAIL max_lasts got=%0d want=15", m_last); end
  endtask
  task automatic test_ignored_start();
    logic [5:0] e [0:6];
    logic [5:0] f [0:4];
    e = '{6'b100010, 6'b000010, 6'b100010, 6'b000110, 6'b000010, 6'b000010, 6'b000001};
    f = '{6'b001010, 6'b000110, 6'b000010, 6'b000010, 6'b000001};
    pulse_start(2'd0, 4'd1);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (obs() !== e[i]) begin bad++; $display("FAIL ignored_run cyc%0d got=%b want=%b", i + 1, obs(), e[i]); end
      bus.start = (i == 2 || i == 6);
      bus.sel = i == 2 ? 2'd1 : 2'd2;
      bus.count = 4'd2;
      step();
    end
    total++;
    if (obs() !== 6'b0) begin bad++; $display("FAIL fin_start_ignored got=%b want=%b", obs(), 6'b0); end
    bus.sel = 2'd2;
    bus.count = 4'd1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (obs() !== f[i]) begin bad++; $display("FAIL back_to_back cyc%0d got=%b want=%b", i + 1, obs(), f[i]); end
      step();
    end
  endtask
  task automatic test_reset_mid();
    pulse_start(2'd0, 4'd1);
    repeat (2) step();
    total++;
    if (obs() !== 6'b100010) begin bad++; $display("FAIL mid_third_bit got=%b want=%b", obs(), 6'b100010); end
    reset = 1'b0;
    #1;
    total++;
    if (obs() !== 6'b0) begin bad++; $display("FAIL mid_reset_async got=%b want=%b", obs(), 6'b0); end
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      total++;
      if (obs() !== 6'b0) begin bad++; $display("FAIL mid_reset_after%0d got=%b want=%b", i, obs(), 6'b0); end
    end
  endtask
`ifdef PATGEN_ABORT_EN
  task automatic test_abort();
    pulse_start(2'd0, 4'd1);
    repeat (2) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    total++;
    if (obs() !== 6'b0) begin bad++; $display("FAIL abort_clear got=%b want=%b", obs(), 6'b0); end
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (obs() !== 6'b0) begin bad++; $display("FAIL abort_after%0d got=%b want=%b", i, obs(), 6'b0); end
    end
    bus.abort = 1'b1;
    pulse_start(2'd0, 4'd1);
    bus.abort = 1'b0;
    total++;
    if (obs() !== 6'b100010) begin bad++; $display("FAIL abort_restart got=%b want=%b", obs(), 6'b100010); end
    repeat (6) step();
    total++;
    if (obs() !== 6'b000001) begin bad++; $display("FAIL abort_restart_done got=%b want=%b", obs(), 6'b000001); end
    repeat (3) step();
  endtask
`endif
  initial begin
    test_reset();
    test_single_w();
    test_x_count0();
    test_all_mode();
    test_max_count();
    test_ignored_start();
    test_reset_mid();
`ifdef PATGEN_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
